// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite bitmap writer: default geometry, colour-key default,
// FSM state encoding and RGB888 / RGB332 field positions.
package sprite_pkg;

   localparam int unsigned DefaultWidthX      = 57;
   localparam int unsigned DefaultHeightY     = 30;
   localparam logic [7:0]  DefaultTransparent = 8'hFF;

   // Bitmap RAM address width, sized for the default 57x30 = 1710 pixel bitmap.
   localparam int unsigned AddrWidth = 11;

   // RGB888 source layout {R[7:0],G[7:0],B[7:0]}: MSB of each channel.
   localparam int unsigned RgbRMsb = 23;
   localparam int unsigned RgbGMsb = 15;
   localparam int unsigned RgbBMsb = 7;

   // RGB332 target layout {R[2:0],G[2:0],B[1:0]}.
   localparam int unsigned Q332RBits = 3;
   localparam int unsigned Q332GBits = 3;
   localparam int unsigned Q332BBits = 2;
   localparam int unsigned Q332RLsb  = 5;
   localparam int unsigned Q332GLsb  = 2;
   localparam int unsigned Q332BLsb  = 0;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StDone
   } state_e;

   function automatic int unsigned clog2_min1(input int unsigned value);
      return (value <= 1) ? 1 : $clog2(value);
   endfunction

endpackage

// File: rtl/rgb888_to_rgb332.sv
// Combinational RGB888 -> RGB332 truncating quantiser with colour-key substitution.
// Optional SPRITE_KEY_PROTECT_EN keeps opaque pixels that quantise onto the key visible.
module rgb888_to_rgb332
   import sprite_pkg::*;
#(
   parameter logic [7:0] TRANSPARENT_ENCODING = DefaultTransparent
) (
   input  logic [23:0] rgb,
   input  logic        transparent,
   output logic [7:0]  rgb332
);

   logic [7:0] quant;
   logic       unused_rgb;

   // Low-order channel bits are dropped by truncation.
   assign unused_rgb = ^{rgb[20:16], rgb[12:8], rgb[5:0]};

   always_comb begin
      quant = '0;
      quant[Q332RLsb +: Q332RBits] = rgb[RgbRMsb -: Q332RBits];
      quant[Q332GLsb +: Q332GBits] = rgb[RgbGMsb -: Q332GBits];
      quant[Q332BLsb +: Q332BBits] = rgb[RgbBMsb -: Q332BBits];
   end

   always_comb begin
      rgb332 = quant;
      if (transparent) begin
         rgb332 = TRANSPARENT_ENCODING;
`ifdef SPRITE_KEY_PROTECT_EN
      end else if (quant == TRANSPARENT_ENCODING) begin
         rgb332 = {quant[7:1], 1'b0};
`else
      end else begin
         rgb332 = quant;
`endif
      end
   end

endmodule

// File: rtl/sprite_bitmap_writer.sv
// Streams one bitmap of RGB888 pixels into an RGB332 bitmap RAM, row-major, with a
// registered one-cycle write path. Build option SPRITE_KEY_PROTECT_EN (see quantiser).
module sprite_bitmap_writer
   import sprite_pkg::*;
#(
   parameter int unsigned OBJECT_WIDTH_X       = DefaultWidthX,
   parameter int unsigned OBJECT_HEIGHT_Y      = DefaultHeightY,
   parameter logic [7:0]  TRANSPARENT_ENCODING = DefaultTransparent
) (
   input  logic                 clk,
   input  logic                 resetN,
   input  logic                 start,
   input  logic                 abort,
   input  logic                 pixel_valid,
   output logic                 pixel_ready,
   input  logic [23:0]          pixel_rgb,
   input  logic                 pixel_transparent,
   output logic                 wr_en,
   output logic [AddrWidth-1:0] wr_addr,
   output logic [7:0]           wr_data,
   output logic                 busy,
   output logic                 done
);

   localparam int unsigned XW = clog2_min1(OBJECT_WIDTH_X);
   localparam int unsigned YW = clog2_min1(OBJECT_HEIGHT_Y);
   localparam logic [XW-1:0] XLast = XW'(OBJECT_WIDTH_X - 1);
   localparam logic [YW-1:0] YLast = YW'(OBJECT_HEIGHT_Y - 1);

   state_e               state_q, state_d;
   logic [XW-1:0]        x_q, x_d;
   logic [YW-1:0]        y_q, y_d;
   logic [AddrWidth-1:0] addr_q, addr_d;

   logic                 wr_en_q;
   logic [AddrWidth-1:0] wr_addr_q;
   logic [7:0]           wr_data_q;

   logic                 accept;
   logic                 last_pixel;
   logic [7:0]           pixel_332;

   rgb888_to_rgb332 #(
      .TRANSPARENT_ENCODING(TRANSPARENT_ENCODING)
   ) u_quant (
      .rgb        (pixel_rgb),
      .transparent(pixel_transparent),
      .rgb332     (pixel_332)
   );

   // abort masks ready, so an abort coinciding with the final pixel never completes the load.
   assign pixel_ready = (state_q == StLoad) && !abort;
   assign accept      = pixel_valid && pixel_ready;
   assign last_pixel  = (x_q == XLast) && (y_q == YLast);

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      addr_d  = addr_q;
      unique case (state_q)
         StIdle: begin
            if (start && !abort) begin
               state_d = StLoad;
               x_d     = '0;
               y_d     = '0;
               addr_d  = '0;
            end
         end
         StLoad: begin
            if (abort) begin
               state_d = StIdle;
            end else if (accept) begin
               // Linear address tracks x/y incrementally instead of y*width+x.
               addr_d = addr_q + 1'b1;
               if (x_q == XLast) begin
                  x_d = '0;
                  y_d = y_q + 1'b1;
               end else begin
                  x_d = x_q + 1'b1;
               end
               if (last_pixel) begin
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (resetN) begin
         state_q   <= StIdle;
         x_q       <= '0;
         y_q       <= '0;
         addr_q    <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= TRANSPARENT_ENCODING;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         addr_q  <= addr_d;
         wr_en_q <= accept;
         if (accept) begin
            wr_addr_q <= addr_q;
            wr_data_q <= pixel_332;
         end
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   // DONE is entered on the edge that registers the final write, so done aligns with it.
   assign busy    = (state_q != StIdle);
   assign done    = (state_q == StDone);

endmodule

// File: tb/tb_sprite_bitmap_writer.sv
// Directed self-checking bench for sprite_bitmap_writer (default 57x30 geometry, key 8'hFF).
module tb_sprite_bitmap_writer;

   logic        clk = 1'b0;
   logic        resetN;
   logic        start;
   logic        abort;
   logic        pixel_valid;
   logic        pixel_ready;
   logic [23:0] pixel_rgb;
   logic        pixel_transparent;
   logic        wr_en;
   logic [10:0] wr_addr;
   logic [7:0]  wr_data;
   logic        busy;
   logic        done;

   int checks   = 0;
   int failures = 0;

`ifdef SPRITE_KEY_PROTECT_EN
   localparam logic [7:0] WhiteQ = 8'hFE;
`else
   localparam logic [7:0] WhiteQ = 8'hFF;
`endif

   sprite_bitmap_writer dut (
      .clk              (clk),
      .resetN           (resetN),
      .start            (start),
      .abort            (abort),
      .pixel_valid      (pixel_valid),
      .pixel_ready      (pixel_ready),
      .pixel_rgb        (pixel_rgb),
      .pixel_transparent(pixel_transparent),
      .wr_en            (wr_en),
      .wr_addr          (wr_addr),
      .wr_data          (wr_data),
      .busy             (busy),
      .done             (done)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      resetN = 1'b1; start = 1'b0; abort = 1'b0; pixel_valid = 1'b0;
      pixel_rgb = '0; pixel_transparent = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({wr_en, done, busy, pixel_ready} !== 4'b0000 || wr_addr !== 11'd0
          || wr_data !== 8'hFF) begin
         failures++;
         $display("FAIL reset_state got en/done/busy/rdy=%b addr=%0d data=%h exp 0000 0 ff",
                  {wr_en, done, busy, pixel_ready}, wr_addr, wr_data);
      end
      resetN = 1'b0;
      @(negedge clk);
   endtask

   // First pixel, row wrap at pixel 57, transparent pixel, and a mid-grey quantisation.
   task automatic test_pattern();
      logic [7:0] exp_data;
      pulse_start();
      checks++;
      if (busy !== 1'b1 || pixel_ready !== 1'b1 || wr_en !== 1'b0) begin
         failures++;
         $display("FAIL load_entry got busy=%b rdy=%b en=%b exp 1 1 0", busy, pixel_ready, wr_en);
      end
      for (int i = 0; i < 60; i++) begin
         pixel_valid       = 1'b1;
         pixel_transparent = (i == 57);
         case (i)
            0:       pixel_rgb = 24'hE0A0C0;
            57:      pixel_rgb = 24'h123456;
            58:      pixel_rgb = 24'h204080;
            default: pixel_rgb = 24'hFFFFFF;
         endcase
         @(negedge clk);
         exp_data = (i == 0) ? 8'hF7 : (i == 57) ? 8'hFF : (i == 58) ? 8'h2A : WhiteQ;
         checks++;
         if (wr_en !== 1'b1 || wr_addr !== 11'(i) || wr_data !== exp_data) begin
            failures++;
            $display("FAIL pattern_write[%0d] got en=%b addr=%0d data=%h exp 1 %0d %h",
                     i, wr_en, wr_addr, wr_data, i, exp_data);
         end
      end
      pixel_valid = 1'b0; pixel_transparent = 1'b0; abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL pattern_abort_idle got busy=%b exp 0", busy);
      end
   endtask

   task automatic test_full_stream();
      int         sent = 0;
      int         nwr = 0;
      int         ndone = 0;
      int         done_cyc = -1;
      logic [10:0] exp_addr = '0;
      pulse_start();
      pixel_valid = 1'b1; pixel_rgb = 24'hFFFFFF; pixel_transparent = 1'b0;
      for (int cyc = 0; cyc < 1720; cyc++) begin
         @(negedge clk);
         if (pixel_valid) sent++;
         if (sent == 1710) pixel_valid = 1'b0;
         if (wr_en) begin
            checks++;
            if (wr_addr !== exp_addr || wr_data !== WhiteQ) begin
               failures++;
               $display("FAIL full_write got addr=%0d data=%h exp %0d %h",
                        wr_addr, wr_data, exp_addr, WhiteQ);
            end
            exp_addr++;
            nwr++;
         end
         if (done) begin
            ndone++;
            done_cyc = cyc;
            checks++;
            if (wr_en !== 1'b1 || wr_addr !== 11'd1709) begin
               failures++;
               $display("FAIL full_done_align got en=%b addr=%0d exp 1 1709", wr_en, wr_addr);
            end
         end
      end
      checks++;
      if (nwr != 1710 || ndone != 1 || done_cyc != 1709 || busy !== 1'b0) begin
         failures++;
         $display("FAIL full_summary got writes=%0d dones=%0d done_cyc=%0d busy=%b exp 1710 1 1709 0",
                  nwr, ndone, done_cyc, busy);
      end
   endtask

   // Random valid gaps plus a start pulse mid-load that must be ignored.
   task automatic test_back_to_back();
      int          sent = 0;
      int          nwr = 0;
      int          ndone = 0;
      int          done_cyc = -1;
      logic [10:0] exp_addr = '0;
      logic [7:0]  exp_data;
      pulse_start();
      pixel_valid = 1'(($urandom_range(0, 1)));
      pixel_rgb   = 24'hE0A0C0;
      for (int cyc = 0; cyc < 6000; cyc++) begin
         @(negedge clk);
         if (pixel_valid) sent++;
         if (wr_en) begin
            exp_data = exp_addr[0] ? 8'h2A : 8'hF7;
            checks++;
            if (wr_addr !== exp_addr || wr_data !== exp_data) begin
               failures++;
               $display("FAIL b2b_write got addr=%0d data=%h exp %0d %h",
                        wr_addr, wr_data, exp_addr, exp_data);
            end
            exp_addr++;
            nwr++;
         end
         if (done) begin
            ndone++;
            done_cyc = cyc;
         end
         start       = (cyc == 300);
         pixel_valid = (sent < 1710) ? 1'($urandom_range(0, 1)) : 1'b0;
         pixel_rgb   = sent[0] ? 24'h204080 : 24'hE0A0C0;
         if (ndone != 0 && cyc > done_cyc + 5) break;
      end
      start = 1'b0; pixel_valid = 1'b0;
      checks++;
      if (nwr != 1710 || ndone != 1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL b2b_summary got writes=%0d dones=%0d busy=%b exp 1710 1 0",
                  nwr, ndone, busy);
      end
   endtask

   task automatic test_abort_mid();
      pulse_start();
      pixel_valid = 1'b1; pixel_rgb = 24'hFFFFFF;
      for (int i = 0; i < 100; i++) @(negedge clk);
      abort = 1'b1;
      #1;
      checks++;
      if (pixel_ready !== 1'b0) begin
         failures++;
         $display("FAIL abort_ready_comb got %b exp 0", pixel_ready);
      end
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b0 || wr_addr !== 11'd99 || done !== 1'b0 || busy !== 1'b0
          || pixel_ready !== 1'b0) begin
         failures++;
         $display("FAIL abort_after got en=%b addr=%0d done=%b busy=%b rdy=%b exp 0 99 0 0 0",
                  wr_en, wr_addr, done, busy, pixel_ready);
      end
      abort = 1'b0; pixel_valid = 1'b0;
      pulse_start();
      pixel_valid = 1'b1; pixel_rgb = 24'hE0A0C0;
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== 11'd0 || wr_data !== 8'hF7) begin
         failures++;
         $display("FAIL abort_restart got en=%b addr=%0d data=%h exp 1 0 f7",
                  wr_en, wr_addr, wr_data);
      end
      pixel_valid = 1'b0; abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
   endtask

   task automatic test_abort_final();
      int          nwr = 0;
      logic [10:0] last_addr = '0;
      pulse_start();
      pixel_valid = 1'b1; pixel_rgb = 24'hFFFFFF;
      for (int i = 0; i < 1709; i++) begin
         @(negedge clk);
         if (wr_en) begin
            nwr++;
            last_addr = wr_addr;
         end
      end
      abort = 1'b1;
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL abort_final got en=%b done=%b busy=%b exp 0 0 0", wr_en, done, busy);
      end
      checks++;
      if (nwr != 1709 || last_addr !== 11'd1708) begin
         failures++;
         $display("FAIL abort_final_count got writes=%0d last=%0d exp 1709 1708", nwr, last_addr);
      end
      abort = 1'b0; pixel_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_start_abort_idle();
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || pixel_ready !== 1'b0) begin
         failures++;
         $display("FAIL start_abort_idle got busy=%b rdy=%b exp 0 0", busy, pixel_ready);
      end
   endtask

   task automatic test_reset_mid_load();
      pulse_start();
      pixel_valid = 1'b1; pixel_rgb = 24'h204080;
      repeat (10) @(negedge clk);
      resetN = 1'b1;
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || wr_addr !== 11'd0
          || wr_data !== 8'hFF) begin
         failures++;
         $display("FAIL reset_mid_load got en=%b done=%b busy=%b addr=%0d data=%h exp 0 0 0 0 ff",
                  wr_en, done, busy, wr_addr, wr_data);
      end
      resetN = 1'b0; pixel_valid = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      resetN = 1'b1; start = 1'b0; abort = 1'b0; pixel_valid = 1'b0;
      pixel_rgb = '0; pixel_transparent = 1'b0;
      test_reset();
      test_pattern();
      test_full_stream();
      test_back_to_back();
      test_abort_mid();
      test_abort_final();
      test_start_abort_idle();
      test_reset_mid_load();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sprite_bitmap_writer.md
SPRITE_BITMAP_WRITER -- requirements
Module: sprite_bitmap_writer

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 SHALL have parameter OBJECT_WIDTH_X, default 57, bitmap width in pixels.
REQ-003 SHALL have parameter OBJECT_HEIGHT_Y, default 30, bitmap height in pixels.
REQ-004 SHALL have parameter TRANSPARENT_ENCODING, default 8'hFF, RGB332 code meaning "do not draw".
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port resetN  input  1  synchronous reset, active-high (1 = reset).
REQ-007 SHALL have port start  input  1  single-cycle request to begin loading one bitmap.
REQ-008 SHALL have port abort  input  1  cancel the load in progress.
REQ-009 SHALL have port pixel_valid  input  1  pixel_rgb and pixel_transparent are valid.
REQ-010 SHALL have port pixel_ready  output  1  block accepts a pixel this cycle.
REQ-011 SHALL have port pixel_rgb  input  24  pixel colour as {R[7:0],G[7:0],B[7:0]}.
REQ-012 SHALL have port pixel_transparent  input  1  pixel is background.
REQ-013 SHALL have port wr_en  output  1  bitmap RAM write strobe.
REQ-014 SHALL have port wr_addr  output  11  linear RAM address, row-major.
REQ-015 SHALL have port wr_data  output  8  RGB332 word.
REQ-016 SHALL have port busy  output  1  a load is in progress.
REQ-017 SHALL have port done  output  1  one-cycle pulse when a full bitmap has been written.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, DONE.
REQ-019 IDLE: start=1 -> LOAD next cycle; x, y and address counters cleared to 0.
REQ-020 LOAD: pixel_ready = 1 when abort=0; pixel_ready = 0 in IDLE, in DONE and whenever abort=1.
REQ-021 Handshake: a pixel is accepted on a cycle with pixel_valid && pixel_ready; holding pixel_valid with pixel_ready low SHALL NOT advance the counters.
REQ-022 Per accepted pixel, wr_en=1, wr_addr=y*OBJECT_WIDTH_X+x and wr_data SHALL appear on the next cycle; latency is exactly 1 cycle.
REQ-023 Address SHALL be kept in an incrementing counter, not produced by a multiplier; x wraps from OBJECT_WIDTH_X-1 to 0 and increments y.
REQ-024 Quantisation: wr_data = {R[7:5],G[7:5],B[7:6]} (truncation, no rounding).
REQ-025 pixel_transparent=1 -> wr_data = TRANSPARENT_ENCODING regardless of pixel_rgb.
REQ-026 Accepting the pixel at x=OBJECT_WIDTH_X-1, y=OBJECT_HEIGHT_Y-1 -> DONE next cycle.
REQ-027 DONE lasts one cycle with done=1 (coincident with the final wr_en), then -> IDLE.
REQ-028 abort=1 in LOAD -> IDLE next cycle; no done; writes already issued stand.
REQ-029 abort and the final pixel in the same cycle: abort wins; the pixel is not accepted and done stays 0.
REQ-030 start in LOAD or DONE SHALL be ignored; start and abort both high in IDLE -> stay IDLE.
REQ-031 busy = 1 in LOAD and DONE, 0 in IDLE.

Reset
REQ-032 resetN=1 -> state IDLE and all counters 0; wr_en, done, busy and pixel_ready = 0; wr_addr = 0; wr_data = TRANSPARENT_ENCODING.
REQ-033 Reset mid-LOAD SHALL suppress the pending registered write and any done pulse.

Configuration
REQ-034 Macro SPRITE_KEY_PROTECT_EN defined: an opaque pixel whose quantised value equals TRANSPARENT_ENCODING SHALL be written with bit 0 cleared (8'hFE), so it stays visible.
REQ-035 Macro not defined: such a pixel is written unmodified and so becomes transparent.

Structure
REQ-036 The package sprite_pkg SHALL hold the default dimensions, the TRANSPARENT_ENCODING default, the FSM state enum and the RGB332 field positions.
REQ-037 Quantisation and key protection SHALL be in the combinational sub-module rgb888_to_rgb332; FSM and counters stay at top level.

Verification
REQ-038 Reset then start, stream 1710 opaque pixels of 24'hFFFFFF with valid held high -> writes at addresses 0..1709, one per cycle; done=1 on the cycle of the address-1709 write; with SPRITE_KEY_PROTECT_EN the data is 8'hFE, without it 8'hFF.
REQ-039 Pixel 24'hE0_A0_C0, opaque, as the first pixel -> wr_addr=0, wr_data=8'hF7, one cycle after acceptance.
REQ-040 Pixel 58 of the stream (x=57 wrap) -> wr_addr=57, i.e. y=1, x=0; a transparent pixel -> wr_data=8'hFF.
REQ-041 Toggle pixel_valid randomly over 1710 pixels -> exactly 1710 writes, no gaps in address, no duplicates, single done pulse.
REQ-042 abort at pixel 100 -> last wr_addr=99, pixel_ready=0 the following cycle, no done; a subsequent start restarts from address 0.
REQ-043 abort asserted together with the final pixel -> no write to 1709, done=0; resetN=1 mid-load -> wr_en=0 the next cycle.
